// File: rtl/ppa_pkg.sv
// Shared definitions for the parallel-prefix adder self-test slice.
package ppa_pkg;

   localparam int unsigned PPA_WIDTH = 6;
   localparam int unsigned VEC_W     = 2 * PPA_WIDTH + 1;
   localparam int unsigned VEC_COUNT = 1 << VEC_W;
   localparam int unsigned ERR_W     = 2 * PPA_WIDTH + 2;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_DRIVE = 2'd1,
      ST_CHECK = 2'd2,
      ST_DONE  = 2'd3
   } ppa_state_e;

   // Width helpers so the driver can be built for any operand width.
   function automatic int unsigned vec_w(input int unsigned width);
      return 2 * width + 1;
   endfunction

   function automatic int unsigned err_w(input int unsigned width);
      return 2 * width + 2;
   endfunction

endpackage

// File: rtl/ppa_ref_model.sv
// Combinational reference for a WIDTH-bit adder with carry-in: sum = {ov, w}.
module ppa_ref_model #(
   parameter int unsigned WIDTH = 6
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             c,
   output logic [WIDTH:0]   sum
);

   localparam int unsigned SW = WIDTH + 1;

   assign sum = {1'b0, a} + {1'b0, b} + SW'(c);

endmodule

// File: rtl/ppa_adder_driver.sv
// Exhaustive operand sequencer and result checker for an external adder.
module ppa_adder_driver
   import ppa_pkg::*;
#(
   parameter int unsigned WIDTH  = PPA_WIDTH,
   parameter int unsigned SETTLE = 2
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   input  logic                 abort,
   output logic [WIDTH-1:0]     a_out,
   output logic [WIDTH-1:0]     b_out,
   output logic                 c_out,
   input  logic [WIDTH-1:0]     w_in,
   input  logic                 ov_in,
   output logic                 busy,
   output logic                 done,
   output logic                 pass,
   output logic [2*WIDTH+1:0]   err_count,
   output logic [2*WIDTH:0]     fail_vec
);

   localparam int unsigned VW    = vec_w(WIDTH);
   localparam int unsigned EW    = err_w(WIDTH);
   localparam int unsigned SET_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;

   ppa_state_e         state_q, state_d;
   logic [VW-1:0]      vec_q, vec_d;
   logic [SET_W-1:0]   settle_q, settle_d;
   logic [EW-1:0]      err_q, err_d;
   logic [VW-1:0]      fail_q, fail_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;
   logic               pass_q, pass_d;
   logic [WIDTH:0]     exp_sum;
   logic               mismatch;

   ppa_ref_model #(.WIDTH(WIDTH)) u_ref (
      .a   (vec_q[WIDTH-1:0]),
      .b   (vec_q[2*WIDTH-1:WIDTH]),
      .c   (vec_q[2*WIDTH]),
      .sum (exp_sum)
   );

   assign mismatch = ({ov_in, w_in} != exp_sum);

   // Next-state and next-output logic.
   always_comb begin
      state_d  = state_q;
      vec_d    = vec_q;
      settle_d = settle_q;
      err_d    = err_q;
      fail_d   = fail_q;
      busy_d   = busy_q;
      done_d   = done_q;
      pass_d   = pass_q;
      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (start) begin
               state_d  = ST_DRIVE;
               vec_d    = '0;
               settle_d = '0;
               err_d    = '0;
               fail_d   = '0;
               busy_d   = 1'b1;
               done_d   = 1'b0;
               pass_d   = 1'b0;
            end
         end
         ST_DRIVE: begin
            if (abort) begin
               state_d = ST_IDLE;
               busy_d  = 1'b0;
            end else if (settle_q == SET_W'(SETTLE - 1)) begin
               state_d = ST_CHECK;
            end else begin
               settle_d = settle_q + SET_W'(1);
            end
         end
         ST_CHECK: begin
            if (abort) begin
               state_d = ST_IDLE;
               busy_d  = 1'b0;
            end else begin
               // Only the first failing vector is latched; the count saturates.
               if (mismatch) begin
                  if (err_q != '1) err_d = err_q + EW'(1);
                  if (err_q == '0) fail_d = vec_q;
               end
               if (vec_q == '1) begin
                  state_d = ST_DONE;
                  busy_d  = 1'b0;
                  done_d  = 1'b1;
                  pass_d  = (err_d == '0);
               end else begin
                  state_d  = ST_DRIVE;
                  vec_d    = vec_q + VW'(1);
                  settle_d = '0;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         vec_q    <= '0;
         settle_q <= '0;
         err_q    <= '0;
         fail_q   <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         pass_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         vec_q    <= vec_d;
         settle_q <= settle_d;
         err_q    <= err_d;
         fail_q   <= fail_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         pass_q   <= pass_d;
      end
   end

   assign a_out     = vec_q[WIDTH-1:0];
   assign b_out     = vec_q[2*WIDTH-1:WIDTH];
   assign c_out     = vec_q[2*WIDTH];
   assign busy      = busy_q;
   assign done      = done_q;
   assign pass      = pass_q;
   assign err_count = err_q;
   assign fail_vec  = fail_q;

endmodule

// File: doc/ppa_adder_driver.md
# ppa_adder_driver

Self-test sequencer that sits on the operand side of the 6-bit parallel-prefix adder. It drives every `{c, b, a}` operand combination into an external adder instance through registered outputs. After a settle window it samples the adder's `w` and `ov` outputs and compares them against an internal `a + b + c` reference. It accumulates an error count, captures the first failing vector, and reports pass/fail, giving the adder an on-chip, synthesizable checker in place of a simulation-only bench.

## Interface
Parameters:
- `WIDTH`, 6, operand width; must match the adder under test
- `SETTLE`, 2, cycles operands are held before the result is sampled (≥1)

Ports:
- `clk` in 1: single clock, rising edge
- `rst_n` in 1: asynchronous, active-low reset
- `start` in 1: begin a sweep; sampled only in IDLE or DONE
- `abort` in 1: stop the sweep; return to IDLE
- `a_out` out WIDTH: operand a to the adder
- `b_out` out WIDTH: operand b to the adder
- `c_out` out 1: carry-in to the adder
- `w_in` in WIDTH: sum from the adder
- `ov_in` in 1: carry-out from the adder
- `busy` out 1: sweep in progress
- `done` out 1: sweep complete; held until next `start`
- `pass` out 1: `err_count == 0`; valid while `done`
- `err_count` out 2·WIDTH+2: number of mismatching vectors; saturates at all-ones
- `fail_vec` out 2·WIDTH+1: `{c, b, a}` of the first mismatch; 0 if none

## Operation
- States: IDLE, DRIVE, CHECK, DONE.
- Vector counter `vec` is 2·WIDTH+1 bits, with `{c_out, b_out, a_out} = vec`. `a` increments fastest. The sweep covers 0 … 2^(2·WIDTH+1)−1, which is 8192 vectors for WIDTH=6.
- IDLE/DONE, `start`=1:
  - clear `vec`, `err_count`, `fail_vec`, and `done`
  - go to DRIVE; assert `busy`
- DRIVE: operands are stable from `vec`. The settle counter counts SETTLE cycles, then the FSM goes to CHECK.
- CHECK (one cycle):
  - expected = `{1'b0,a} + {1'b0,b} + c`, computed at WIDTH+1 bits
  - mismatch if `{ov_in, w_in}` ≠ expected
  - on mismatch: `err_count`+1 (saturating); on the first mismatch only, latch `fail_vec` = `vec`
  - if `vec` is the last vector: go to DONE, `busy`=0, `done`=1
  - otherwise: `vec`+1, go back to DRIVE
- DONE: operands hold the last vector; `err_count`, `fail_vec`, and `pass` hold.
- `abort` in DRIVE or CHECK:
  - next state IDLE; `busy`=0; `done` stays 0
  - `err_count` and `fail_vec` keep their partial values
  - abort has priority over a CHECK-cycle transition
- `start` while `busy` is ignored. `abort` in IDLE or DONE is ignored. If `start` and `abort` are both asserted in IDLE/DONE, `start` wins.

## Timing
- Reset values (asynchronous, immediate): state IDLE; all outputs 0, including `a_out`, `b_out`, `c_out`, `busy`, `done`, `pass`, `err_count`, `fail_vec`.
- Reset asserted mid-sweep returns the block to the reset values. No partial results survive.
- `start` sampled at edge T:
  - `busy`=1 and vector 0 is driven from T+1
  - the first CHECK is at T+1+SETTLE
- Each vector takes SETTLE+1 cycles. Full sweep = 2^(2·WIDTH+1)·(SETTLE+1) cycles: 24576 for defaults.
- `done` rises, and `busy` falls, on the edge after the final CHECK.
- Operand outputs are registered. They change only on the edge leaving CHECK, never inside the settle window.
- `w_in` and `ov_in` are sampled only in CHECK. The adder path must settle within SETTLE cycles.

## Structure
- Shared package `ppa_pkg` contains:
  - `PPA_WIDTH` = 6
  - the state enum (IDLE, DRIVE, CHECK, DONE)
  - the `VEC_COUNT` and `ERR_W` derivations
- One sub-module, `ppa_ref_model`: combinational expected `{ov, w}` from `a`, `b`, `c`, WIDTH-parameterized, reusable by other adder variants.
- FSM, settle counter, vector counter, and error logic stay in `ppa_adder_driver`.

## Test plan
- Correct adder connected, `start` pulse: `done`=1 after 24576 cycles, `pass`=1, `err_count`=0, `fail_vec`=0.
- Adder with `ov` stuck at 0: `err_count`=4096, `pass`=0, `fail_vec`=13'h007F (c=0, b=000001, a=111111).
- Adder with `w[0]` stuck at 0: `err_count`=4096, `fail_vec`=13'h0001.
- `abort` at cycle 100 of a sweep:
  - `busy`=0 next cycle, `done`=0
  - a second `start` completes a full sweep with `err_count` restarted from 0
- `rst_n` low mid-sweep: all outputs 0 immediately, FSM in IDLE. `start` pulses while `busy` do not restart `vec`, which is checked by monotonic `{c,b,a}` progression.
- SETTLE=1 build with a fault that forces `w` to 6'b111111 whenever a=6'b110100, b=6'b000111, c=1 (correct value 6'b111100): `err_count`=1, `fail_vec`={1,000111,110100}, total sweep 16384 cycles.
